// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types and constants for the PS/2 mouse link controller.
//   state_e   - sequencer state encoding
//   rx_err_t  - receiver error code (0 = byte received cleanly)
//   CMD_*/RSP_* - command bytes sent to, and response bytes expected from, the mouse
package mouse_pkg;

  typedef enum logic [3:0] {
    StInitSendFf,
    StWaitAck1,
    StWaitBat,
    StWaitId,
    StSendF4,
    StWaitAck2,
    StStreamB0,
    StStreamB1,
    StStreamB2,
    StHostSend,
    StHostAck,
    StFail
  } state_e;

  typedef logic [1:0] rx_err_t;
  localparam rx_err_t RX_OK = 2'd0;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  // Byte the mouse must return while the sequencer sits in an init wait state.
  function automatic logic [7:0] init_expect(state_e s);
    case (s)
      StWaitAck1, StWaitAck2: return RSP_ACK;
      StWaitBat:              return RSP_BAT_OK;
      default:                return RSP_ID;
    endcase
  endfunction

  // Successor of an init wait state once its expected byte has arrived.
  function automatic state_e init_next(state_e s);
    case (s)
      StWaitAck1: return StWaitBat;
      StWaitBat:  return StWaitId;
      StWaitId:   return StSendF4;
      default:    return StStreamB0;
    endcase
  endfunction

endpackage

// File: rtl/mouse_timeout_timer.sv
// mouse_timeout_timer: cycle counter shared by all response/packet wait states.
//   CLK, RESET - clock, asynchronous active-high reset
//   clear      - zero the count (first cycle of a new state)
//   enable     - count this cycle
//   limit      - timeout length in cycles
//   expired    - count has reached limit-1 while enabled
module mouse_timeout_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // While clear is high the count still holds the previous state's value, so mask it.
  assign expired = enable && !clear && (count_q == limit - CNT_W'(1));

endmodule

// File: rtl/mouse_cmd_sequencer.sv
// mouse_cmd_sequencer: PS/2 mouse link master. Runs the power-up exchange
// (FF -> FA/AA/00, F4 -> FA), then assembles 3-byte stream packets and slots
// host command bytes into the gaps between packets.
//   CLK, RESET                       - clock, asynchronous active-high reset
//   SEND_BYTE/BYTE_TO_SEND/BYTE_SENT - transmitter handshake
//   READ_ENABLE/BYTE_READ/BYTE_ERROR_CODE/BYTE_READY - receiver interface
//   HOST_CMD_*                       - host command request/accept/completion
//   MOUSE_STATUS/DX/DY, SEND_INTERRUPT - last packet and its strobe
//   INIT_DONE, INIT_FAIL             - init outcome levels
module mouse_cmd_sequencer
  import mouse_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 50_000_000,
  parameter int unsigned PKT_TIMEOUT = 1_000_000,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  input  logic       HOST_CMD_VALID,
  input  logic [7:0] HOST_CMD_BYTE,
  output logic       HOST_CMD_READY,
  output logic       HOST_CMD_DONE,
  output logic       HOST_CMD_ERR,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic       INIT_FAIL
);

  localparam int unsigned RetryW = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

  state_e            state_q, state_prev_q;
  logic              issued_q;  // SEND_BYTE already raised in the current send state
  logic [RetryW-1:0] retry_q;
  logic [7:0]        pkt_status_q, pkt_dx_q;
  logic              rx_ok, rsp_ok;
  logic              tmr_clear, tmr_enable, tmr_expired;
  logic [CNT_W-1:0]  tmr_limit;

  assign rx_ok  = (BYTE_ERROR_CODE == RX_OK);
  assign rsp_ok = rx_ok && (BYTE_READ == init_expect(state_q));

  assign tmr_clear  = (state_q != state_prev_q);
  assign tmr_enable = state_q inside {StWaitAck1, StWaitBat, StWaitId, StWaitAck2,
                                      StStreamB1, StStreamB2, StHostAck};
  assign tmr_limit  = (state_q inside {StStreamB1, StStreamB2}) ? CNT_W'(PKT_TIMEOUT)
                                                                : CNT_W'(RSP_TIMEOUT);

  assign READ_ENABLE = !(state_q inside {StInitSendFf, StSendF4, StHostSend, StFail});
  assign INIT_DONE   = state_q inside {StStreamB0, StStreamB1, StStreamB2,
                                       StHostSend, StHostAck};
  assign INIT_FAIL   = (state_q == StFail);

  mouse_timeout_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= StInitSendFf;
      state_prev_q   <= StInitSendFf;
      issued_q       <= 1'b0;
      retry_q        <= '0;
      pkt_status_q   <= '0;
      pkt_dx_q       <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= CMD_RESET;
      HOST_CMD_READY <= 1'b0;
      HOST_CMD_DONE  <= 1'b0;
      HOST_CMD_ERR   <= 1'b0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      state_prev_q   <= state_q;
      SEND_BYTE      <= 1'b0;
      HOST_CMD_READY <= 1'b0;
      HOST_CMD_DONE  <= 1'b0;
      HOST_CMD_ERR   <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      unique case (state_q)
        StInitSendFf, StSendF4, StHostSend: begin
          // Transitions into a send state raise SEND_BYTE themselves; only the
          // post-reset entry arrives here with nothing issued yet.
          if (!issued_q) begin
            SEND_BYTE <= 1'b1;
            issued_q  <= 1'b1;
          end else if (BYTE_SENT) begin
            issued_q <= 1'b0;
            case (state_q)
              StInitSendFf: state_q <= StWaitAck1;
              StSendF4:     state_q <= StWaitAck2;
              default:      state_q <= StHostAck;
            endcase
          end
        end
        StWaitAck1, StWaitBat, StWaitId, StWaitAck2: begin
          if (BYTE_READY && rsp_ok) begin
            state_q <= init_next(state_q);
            if (state_q == StWaitId) begin
              SEND_BYTE    <= 1'b1;
              issued_q     <= 1'b1;
              BYTE_TO_SEND <= CMD_ENABLE;
            end
          end else if (BYTE_READY || tmr_expired) begin
            if (retry_q == RetryW'(RETRY_MAX - 1)) begin
              state_q <= StFail;
            end else begin
              retry_q      <= retry_q + RetryW'(1);
              state_q      <= StInitSendFf;
              SEND_BYTE    <= 1'b1;
              issued_q     <= 1'b1;
              BYTE_TO_SEND <= CMD_RESET;
            end
          end
        end
        StStreamB0: begin
          // A mouse byte in the same cycle wins; the host simply keeps waiting.
          if (BYTE_READY) begin
            if (rx_ok && BYTE_READ[3]) begin
              pkt_status_q <= BYTE_READ;
              state_q      <= StStreamB1;
            end
          end else if (HOST_CMD_VALID) begin
            HOST_CMD_READY <= 1'b1;
            SEND_BYTE      <= 1'b1;
            issued_q       <= 1'b1;
            BYTE_TO_SEND   <= HOST_CMD_BYTE;
            state_q        <= StHostSend;
          end
        end
        StStreamB1: begin
          if (BYTE_READY) begin
            pkt_dx_q <= BYTE_READ;
            state_q  <= rx_ok ? StStreamB2 : StStreamB0;
          end else if (tmr_expired) begin
            state_q <= StStreamB0;
          end
        end
        StStreamB2: begin
          if (BYTE_READY) begin
            if (rx_ok) begin
              MOUSE_STATUS   <= pkt_status_q;
              MOUSE_DX       <= pkt_dx_q;
              MOUSE_DY       <= BYTE_READ;
              SEND_INTERRUPT <= 1'b1;
            end
            state_q <= StStreamB0;
          end else if (tmr_expired) begin
            state_q <= StStreamB0;
          end
        end
        StHostAck: begin
          if (BYTE_READY || tmr_expired) begin
            HOST_CMD_DONE <= 1'b1;
            HOST_CMD_ERR  <= !(BYTE_READY && rx_ok && (BYTE_READ == RSP_ACK));
            state_q       <= StStreamB0;
          end
        end
        StFail: state_q <= StFail;
        default: state_q <= StInitSendFf;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_cmd_sequencer.sv
module tb_mouse_cmd_sequencer;

  localparam int unsigned RSP      = 40;
  localparam int unsigned PKT      = 20;
  localparam int          LONG_GAP = PKT + 10;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'd0;
  logic       BYTE_READY = 1'b0;
  logic       HOST_CMD_VALID = 1'b0;
  logic [7:0] HOST_CMD_BYTE = 8'h00;
  logic       HOST_CMD_READY, HOST_CMD_DONE, HOST_CMD_ERR;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT, INIT_DONE, INIT_FAIL;

  mouse_cmd_sequencer #(
    .RSP_TIMEOUT (RSP),
    .PKT_TIMEOUT (PKT),
    .RETRY_MAX   (3),
    .CNT_W       (8)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SEND_BYTE       (SEND_BYTE),
    .BYTE_TO_SEND    (BYTE_TO_SEND),
    .BYTE_SENT       (BYTE_SENT),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY),
    .HOST_CMD_VALID  (HOST_CMD_VALID),
    .HOST_CMD_BYTE   (HOST_CMD_BYTE),
    .HOST_CMD_READY  (HOST_CMD_READY),
    .HOST_CMD_DONE   (HOST_CMD_DONE),
    .HOST_CMD_ERR    (HOST_CMD_ERR),
    .MOUSE_STATUS    (MOUSE_STATUS),
    .MOUSE_DX        (MOUSE_DX),
    .MOUSE_DY        (MOUSE_DY),
    .SEND_INTERRUPT  (SEND_INTERRUPT),
    .INIT_DONE       (INIT_DONE),
    .INIT_FAIL       (INIT_FAIL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int tx_cnt = 0, ready_cnt = 0, done_cnt = 0, intr_cnt = 0;
  int model_pkts = 0;

  // Reference model state: what the mouse link must produce, in transaction terms.
  logic [7:0]  exp_tx[$];   // bytes the sequencer must hand to the transmitter, in order
  bit          exp_done[$]; // HOST_CMD_ERR expected at each HOST_CMD_DONE
  logic [23:0] exp_pkt[$];  // {status, dx, dy} expected at each SEND_INTERRUPT
  logic [7:0]  part[$];     // bytes of the stream packet collected so far

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Event monitor: every strobe the DUT raises is checked against the model queues.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (SEND_BYTE) begin
        tx_cnt++;
        check("tx_expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) check("tx_byte", BYTE_TO_SEND, exp_tx.pop_front());
      end
      if (HOST_CMD_READY) ready_cnt++;
      if (HOST_CMD_DONE) begin
        done_cnt++;
        check("done_expected", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) check("done_err", HOST_CMD_ERR, exp_done.pop_front());
      end
      if (SEND_INTERRUPT) begin
        intr_cnt++;
        check("intr_expected", 32'(exp_pkt.size() != 0), 1);
        if (exp_pkt.size() != 0)
          check("pkt_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, exp_pkt.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return tx_cnt;
      1:       return ready_cnt;
      2:       return done_cnt;
      default: return intr_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int base, input int bound, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (get_cnt(sel) > base) seen = 1'b1;
      else @(negedge CLK);
    end
    if (get_cnt(sel) > base) seen = 1'b1;
    check(name, 32'(seen), 1);
  endtask

  task automatic send_ack(input int base, input int bound, input string name);
    wait_cnt(0, base, bound, name);
    check({name, "_rd_en"}, READ_ENABLE, 0);
    repeat (2) @(negedge CLK);
    BYTE_SENT = 1'b1;
    @(negedge CLK);
    BYTE_SENT = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'd0;
  endtask

  task automatic stream_byte(input logic [7:0] b, input logic [1:0] e, input int gap);
    if (e != 2'd0) begin
      part.delete();
    end else if (part.size() != 0 || b[3]) begin
      part.push_back(b);
      if (part.size() == 3) begin
        exp_pkt.push_back({part[0], part[1], part[2]});
        model_pkts++;
        part.delete();
      end
    end
    rx(b, e);
    repeat (gap) @(negedge CLK);
    if (gap >= LONG_GAP) part.delete();
  endtask

  task automatic flush_partial();
    if (part.size() != 0) begin
      repeat (LONG_GAP) @(negedge CLK);
      part.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RESET = 1'b1;
    BYTE_READY = 1'b0;
    BYTE_SENT = 1'b0;
    part.delete();
    exp_tx.push_back(8'hFF);
    repeat (2) @(negedge CLK);
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #2 RESET = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_send"}, SEND_BYTE, 0);
    check({tag, "_tx_byte"}, BYTE_TO_SEND, 8'hFF);
    check({tag, "_rd_en"}, READ_ENABLE, 0);
    check({tag, "_init_done"}, INIT_DONE, 0);
    check({tag, "_init_fail"}, INIT_FAIL, 0);
    check({tag, "_ready"}, HOST_CMD_READY, 0);
    check({tag, "_regs"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT}, 0);
  endtask

  // Full nominal power-up exchange; the 0xFF send must already be expected.
  task automatic do_init(input int base);
    int b;
    send_ack(base, 20, "init_ff_sent");
    check("wait_rd_en", READ_ENABLE, 1);
    rx(8'hFA, 2'd0);
    rx(8'hAA, 2'd0);
    exp_tx.push_back(8'hF4);
    b = tx_cnt;
    rx(8'h00, 2'd0);
    send_ack(b, 20, "init_f4_sent");
    HOST_CMD_VALID = 1'b0;
    rx(8'hFA, 2'd0);
    check("init_done", INIT_DONE, 1);
  endtask

  // kind: 0 = ack reply, 1 = other byte, 2 = rx error, 3 = no reply
  task automatic host_cmd(input logic [7:0] cmd, input int kind);
    int b_tx, b_rdy, b_done;
    logic [7:0] other;
    flush_partial();
    b_tx = tx_cnt;
    b_rdy = ready_cnt;
    b_done = done_cnt;
    exp_tx.push_back(cmd);
    exp_done.push_back(kind != 0);
    @(negedge CLK);
    HOST_CMD_VALID = 1'b1;
    HOST_CMD_BYTE = cmd;
    wait_cnt(1, b_rdy, 10, "host_ready");
    HOST_CMD_VALID = 1'b0;
    send_ack(b_tx, 5, "host_sent");
    other = 8'($urandom);
    if (other == 8'hFA) other = 8'h09;
    case (kind)
      0: rx(8'hFA, 2'd0);
      1: rx(other, 2'd0);
      2: rx(8'hFA, 2'($urandom_range(1, 3)));
      default: ;
    endcase
    wait_cnt(2, b_done, RSP + 30, "host_done");
  endtask

  initial begin
    int b, bi, bd, br;

    // Reset state, and host requests during init must be ignored.
    exp_tx.push_back(8'hFF);
    HOST_CMD_VALID = 1'b1;
    HOST_CMD_BYTE = 8'hF3;
    repeat (3) @(negedge CLK);
    reset_checks("reset");
    b = tx_cnt;
    release_reset();
    do_init(b);
    check("init_two_sends", tx_cnt, 2);
    check("no_ready_in_init", ready_cnt, 0);

    // Pinned packet.
    bi = intr_cnt;
    stream_byte(8'h09, 2'd0, 1);
    stream_byte(8'h05, 2'd0, 1);
    stream_byte(8'hFB, 2'd0, 1);
    check("pkt1_intr", intr_cnt - bi, 1);
    check("pkt1_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h0905FB);

    // Resync on bit3 = 0.
    bi = intr_cnt;
    stream_byte(8'h00, 2'd0, 1);
    stream_byte(8'h08, 2'd0, 1);
    stream_byte(8'h01, 2'd0, 1);
    stream_byte(8'h02, 2'd0, 1);
    check("resync_intr", intr_cnt - bi, 1);
    check("resync_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h080102);

    // Inter-byte stall drops the partial packet.
    bi = intr_cnt;
    stream_byte(8'h08, 2'd0, LONG_GAP);
    check("stall_no_intr", intr_cnt - bi, 0);
    stream_byte(8'h18, 2'd0, 0);
    stream_byte(8'h7F, 2'd0, 0);
    stream_byte(8'h80, 2'd0, 1);
    check("stall_next_intr", intr_cnt - bi, 1);
    check("stall_next_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h187F80);

    // Randomized stream traffic against the packet model.
    bi = intr_cnt;
    b = model_pkts;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] sb;
      logic [1:0] se;
      int sg;
      sb = 8'($urandom);
      if ($urandom_range(0, 3) != 0) sb[3] = 1'b1;
      se = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      sg = ($urandom_range(0, 9) == 0) ? LONG_GAP : int'($urandom_range(0, 4));
      stream_byte(sb, se, sg);
    end
    flush_partial();
    repeat (3) @(negedge CLK);
    check("rand_intr_count", intr_cnt - bi, model_pkts - b);
    check("rand_pkt_drained", exp_pkt.size(), 0);

    // Host commands: acked, then timed out, then randomized.
    bd = done_cnt;
    host_cmd(8'hF3, 0);
    check("host_ok_done", done_cnt - bd, 1);
    host_cmd(8'hF3, 3);
    check("host_to_done", done_cnt - bd, 2);
    for (int i = 0; i < 6; i++) begin
      host_cmd(8'($urandom), int'($urandom_range(0, 3)));
      stream_byte(8'h28, 2'd0, 0);
      stream_byte(8'($urandom), 2'd0, 0);
      stream_byte(8'($urandom), 2'd0, 1);
    end
    check("host_rand_done", done_cnt - bd, 8);

    // Collision: mouse byte and host request in the same cycle.
    flush_partial();
    br = ready_cnt;
    bd = done_cnt;
    b = tx_cnt;
    exp_tx.push_back(8'hF3);
    exp_done.push_back(1'b0);
    part.push_back(8'h08);
    @(negedge CLK);
    HOST_CMD_VALID = 1'b1;
    HOST_CMD_BYTE = 8'hF3;
    BYTE_READ = 8'h08;
    BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    check("coll_no_ready_b1", ready_cnt - br, 0);
    stream_byte(8'h01, 2'd0, 0);
    stream_byte(8'h02, 2'd0, 0);
    check("coll_no_ready_pkt", ready_cnt - br, 0);
    check("coll_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h080102);
    wait_cnt(1, br, 10, "coll_ready_late");
    HOST_CMD_VALID = 1'b0;
    send_ack(b, 5, "coll_sent");
    rx(8'hFA, 2'd0);
    wait_cnt(2, bd, 10, "coll_done");

    // Reset while waiting for BAT, then a clean re-init.
    do_reset();
    reset_checks("reset2");
    b = tx_cnt;
    release_reset();
    send_ack(b, 20, "r2_ff_sent");
    rx(8'hFA, 2'd0);
    do_reset();
    reset_checks("reset_bat");
    b = tx_cnt;
    release_reset();
    do_init(b);
    check("reinit_sends", tx_cnt - b, 2);

    // Three failed attempts: response timeout, rx error, wrong BAT.
    do_reset();
    b = tx_cnt;
    br = ready_cnt;
    release_reset();
    send_ack(b, 20, "f1_ff_sent");
    exp_tx.push_back(8'hFF);
    bd = tx_cnt;
    send_ack(bd, RSP + 40, "f2_ff_after_timeout");
    rx(8'hFA, 2'd0);
    exp_tx.push_back(8'hFF);
    bd = tx_cnt;
    rx(8'hAA, 2'd1);
    send_ack(bd, 20, "f3_ff_after_rxerr");
    rx(8'hFA, 2'd0);
    rx(8'hFC, 2'd0);
    HOST_CMD_VALID = 1'b1;
    HOST_CMD_BYTE = 8'hF3;
    repeat (60) @(negedge CLK);
    check("fail_flag", INIT_FAIL, 1);
    check("fail_not_done", INIT_DONE, 0);
    check("fail_three_sends", tx_cnt - b, 3);
    check("fail_no_ready", ready_cnt - br, 0);
    HOST_CMD_VALID = 1'b0;

    check("tx_queue_empty", exp_tx.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mouse_cmd_sequencer.md
Name: mouse_cmd_sequencer

Overview:
Master controller for the PS/2 mouse link. It sequences the byte-level transmitter (send/ack handshake) and receiver through the power-up init exchange: reset, BAT, ID, then enable-reporting. It then assembles 3-byte stream packets into status/dX/dY registers and arbitrates host-issued command bytes (e.g. set-sample-rate) into gaps between packets.

Parameters:
RSP_TIMEOUT, 50_000_000, cycles allowed per awaited response byte during init/host command (1 s at 50 MHz)
PKT_TIMEOUT, 1_000_000, max cycles between bytes of one stream packet (20 ms)
RETRY_MAX, 3, init attempts before declaring failure
CNT_W, 26, width of the shared timeout counter (must hold max(RSP_TIMEOUT, PKT_TIMEOUT))

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
SEND_BYTE  out  1  one-cycle request to transmitter
BYTE_TO_SEND  out  8  byte for transmitter; held stable from SEND_BYTE until BYTE_SENT
BYTE_SENT  in  1  one-cycle pulse from transmitter, byte done
READ_ENABLE  out  1  receiver enable
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error code, 0 = ok; sampled with BYTE_READY
BYTE_READY  in  1  one-cycle pulse, received byte valid
HOST_CMD_VALID  in  1  host requests sending HOST_CMD_BYTE
HOST_CMD_BYTE  in  8  host command byte
HOST_CMD_READY  out  1  one-cycle pulse, command accepted
HOST_CMD_DONE  out  1  one-cycle pulse, mouse response received or timed out
HOST_CMD_ERR  out  1  valid with HOST_CMD_DONE: 1 = response not 0xFA, rx error, or timeout
MOUSE_STATUS  out  8  last packet byte 0
MOUSE_DX  out  8  last packet byte 1
MOUSE_DY  out  8  last packet byte 2
SEND_INTERRUPT  out  1  one-cycle pulse, new packet registered
INIT_DONE  out  1  level, stream mode reached
INIT_FAIL  out  1  level, RETRY_MAX attempts exhausted

Behaviour:
- Reset: state = INIT_SEND_FF; all outputs 0 except BYTE_TO_SEND = 0xFF; retry count 0, timer 0. Reset mid-transfer aborts immediately; the transmitter is not informed.
- Init states:
  - INIT_SEND_FF: pulse SEND_BYTE in the first cycle of the state, wait for BYTE_SENT, go to WAIT_ACK1.
  - WAIT_ACK1: expect 0xFA. WAIT_BAT: expect 0xAA. WAIT_ID: expect 0x00.
  - SEND_F4: send 0xF4, then WAIT_ACK2 expecting 0xFA, then STREAM_B0 with INIT_DONE = 1.
- SEND_BYTE: exactly one pulse per send state entry. Any BYTE_SENT arriving outside a send state is ignored.
- READ_ENABLE = 1 in every wait and stream state, 0 in send states.
- Response check: acted on only at BYTE_READY. A mismatched byte or nonzero BYTE_ERROR_CODE is a failure.
- Response timeout: timer clears on state entry and counts each cycle in a wait state. Reaching RSP_TIMEOUT-1 is a failure.
- Init failure: increment retry count; if it equals RETRY_MAX go to FAIL (INIT_FAIL = 1, terminal until reset), else restart at INIT_SEND_FF. BYTE_READY and BYTE_SENT coinciding with the timeout cycle: the byte wins.
- Stream states:
  - STREAM_B0: accept a byte only if bit3 = 1 and error = 0; otherwise discard and stay (resync).
  - STREAM_B1 / STREAM_B2: each has a PKT_TIMEOUT inter-byte timer. On timeout or rx error, drop the partial packet and return to B0; no interrupt.
  - Byte 2 accepted: MOUSE_STATUS/DX/DY update together in the next cycle, SEND_INTERRUPT pulses that same cycle, return to B0. Values are passed raw; overflow bits are not interpreted.
- Host command arbitration:
  - HOST_CMD_VALID is honoured only in STREAM_B0 with no BYTE_READY that cycle. A simultaneous mouse byte has priority and the host keeps waiting.
  - Accept: pulse HOST_CMD_READY, latch the byte, go to HOST_SEND → HOST_ACK (RSP_TIMEOUT).
  - On 0xFA, HOST_CMD_DONE with ERR = 0. On another byte, rx error, or timeout, DONE with ERR = 1. Return to STREAM_B0 in every case.
  - Stream bytes arriving during HOST_ACK that are not 0xFA count as a response error, not packet data.
- HOST_CMD_VALID outside STREAM_B0 (init, FAIL) is never accepted; READY stays 0.
- Latencies: BYTE_READY to next state, 1 cycle. Byte-2 BYTE_READY to SEND_INTERRUPT, 1 cycle.

Decomposition:
- Shared package mouse_pkg: state enum typedef; constants CMD_RESET = 0xFF, CMD_ENABLE = 0xF4, RSP_ACK = 0xFA, RSP_BAT_OK = 0xAA, RSP_ID = 0x00; receiver error-code typedef.
- One sub-module: mouse_timeout_timer (clear, enable, limit input, expired output), instantiated once and shared by all wait states.

Test Plan:
- Nominal init: after SEND_BYTE 0xFF/BYTE_SENT, feed FA, AA, 00; after 0xF4/BYTE_SENT, feed FA → INIT_DONE = 1, exactly 2 SEND_BYTE pulses.
- Wrong BAT: feed FA, then 0xFC → restart with a third SEND_BYTE 0xFF. Three consecutive failures (RETRY_MAX = 3) → INIT_FAIL = 1, no further SEND_BYTE.
- Packet: in stream, feed 0x09, 0x05, 0xFB → one cycle later STATUS = 0x09, DX = 0x05, DY = 0xFB, one SEND_INTERRUPT.
- Resync: feed 0x00 (bit3 = 0), then 0x08, 0x01, 0x02 → exactly one interrupt, STATUS = 0x08. Feed 0x08 then stall past PKT_TIMEOUT → no interrupt; next full packet is reported.
- Host command: HOST_CMD_VALID with 0xF3 in B0 → READY pulse, SEND_BYTE with 0xF3; reply 0xFA → DONE = 1, ERR = 0. Repeat with no reply → DONE after RSP_TIMEOUT, ERR = 1.
- Collision and reset: HOST_CMD_VALID coinciding with BYTE_READY 0x08 → byte consumed, READY delayed until back in B0. Assert RESET during WAIT_BAT → outputs cleared, new 0xFF sent after release.
